// File: rtl/build_block.sv
// -----------------------------------------------------------------------------
// build_block
//   Byte-to-block assembler. Collects BLOCK_BYTES bytes from a byte-serial
//   stream into one block and presents the whole block downstream with a
//   valid/ready handshake.
//
// Handshake semantics (both sides):
//   A transfer happens on a rising clk_in edge where the producer's valid and
//   the consumer's ready are both high. Valid and ready are independent; this
//   block's own ready/valid outputs are pure registered state decodes and never
//   depend combinationally on any input.
//
// Ports:
//   clk_in          system clock, posedge
//   rst_in          asynchronous active-high reset
//   byte_in         incoming byte
//   byte_valid_in   byte_in valid this cycle
//   byte_ready_out  block can accept a byte (state FILL)
//   clear_in        synchronous discard of any partial or held block
//   flush_in        close a partial block early (optional feature)
//   block_out       assembled block, lane 0 = first byte received
//   block_valid_out block_out complete and held (state HOLD)
//   block_ready_in  consumer accepts block_out
//   count_out       bytes stored in the current block
//
// Build option:
//   BUILD_BLOCK_FLUSH_PAD_EN - when defined, flush_in in FILL closes a
//   non-empty partial block, zero-pads the remaining lanes and enters HOLD;
//   count_out then reports the number of real bytes. When undefined, flush_in
//   is ignored.
// -----------------------------------------------------------------------------
module build_block #(
  parameter int BLOCK_BYTES = 16,
  parameter int BYTE_W      = 8,
  parameter int CNT_W       = $clog2(BLOCK_BYTES + 1)
) (
  input  logic                                clk_in,
  input  logic                                rst_in,
  input  logic [BYTE_W-1:0]                   byte_in,
  input  logic                                byte_valid_in,
  output logic                                byte_ready_out,
  input  logic                                clear_in,
  input  logic                                flush_in,
  output logic [BLOCK_BYTES-1:0][BYTE_W-1:0]  block_out,
  output logic                                block_valid_out,
  input  logic                                block_ready_in,
  output logic [CNT_W-1:0]                    count_out
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e                               state_q, state_d;
  logic [CNT_W-1:0]                     count_q, count_d;
  logic [BLOCK_BYTES-1:0][BYTE_W-1:0]   block_q, block_d;
  logic                                 accept;

`ifndef BUILD_BLOCK_FLUSH_PAD_EN
  // flush_in has no function in this build.
  logic unused_flush;
  assign unused_flush = flush_in;
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    block_d = block_q;
    accept  = byte_valid_in && (state_q == FILL) && !clear_in;

    if (clear_in) begin
      // Lanes are left as they are; they are rewritten before the next HOLD.
      state_d = FILL;
      count_d = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            // Loop-compare instead of a direct index keeps the lane select
            // width-exact against the wider counter.
            for (int i = 0; i < BLOCK_BYTES; i++) begin
              if (count_q == CNT_W'(i)) block_d[i] = byte_in;
            end
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_W'(BLOCK_BYTES - 1)) state_d = HOLD;
          end
`ifdef BUILD_BLOCK_FLUSH_PAD_EN
          // A byte arriving with the flush is stored first; padding covers
          // everything after it. A byte that completes the block already
          // took the normal HOLD path above.
          if (flush_in && (count_d != '0) && (state_d == FILL)) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
              if (CNT_W'(i) >= count_d) block_d[i] = '0;
            end
            state_d = HOLD;
          end
`endif
        end
        HOLD: begin
          if (block_ready_in) begin
            state_d = FILL;
            count_d = '0;
          end
        end
        default: begin
          state_d = FILL;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= FILL;
      count_q <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      block_q <= block_d;
    end
  end

  assign byte_ready_out  = (state_q == FILL);
  assign block_valid_out = (state_q == HOLD);
  assign block_out       = block_q;
  assign count_out       = count_q;

endmodule

// File: tb/tb_build_block.sv
// -----------------------------------------------------------------------------
// tb_build_block
//   Directed and random stimulus for build_block. The reference model keeps
//   the bytes of the current block in a queue plus a "block is held" flag.
// -----------------------------------------------------------------------------
module tb_build_block;

  localparam int BB    = 16;
  localparam int BW    = 8;
  localparam int CW    = 5;
  localparam int BLK_W = BB * BW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [BW-1:0]          byte_in = '0;
  logic                   byte_valid = 1'b0;
  logic                   byte_ready;
  logic                   clear = 1'b0;
  logic                   flush = 1'b0;
  logic [BB-1:0][BW-1:0]  block;
  logic                   block_valid;
  logic                   block_ready = 1'b0;
  logic [CW-1:0]          count;

  build_block #(.BLOCK_BYTES(BB), .BYTE_W(BW)) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .byte_in         (byte_in),
    .byte_valid_in   (byte_valid),
    .byte_ready_out  (byte_ready),
    .clear_in        (clear),
    .flush_in        (flush),
    .block_out       (block),
    .block_valid_out (block_valid),
    .block_ready_in  (block_ready),
    .count_out       (count)
  );

  // ---------------- reference model ----------------
  logic [BW-1:0] exp_q[$];     // real bytes of the current block, in order
  logic [BW-1:0] m_lane[BB];   // expected lane contents
  bit            m_hold = 0;

  int checks = 0;
  int errors = 0;

  task automatic model_reset();
    exp_q.delete();
    m_hold = 0;
    for (int i = 0; i < BB; i++) m_lane[i] = '0;
  endtask

  // Applies the rules to the inputs about to be sampled on the next edge.
  task automatic model_update();
    if (clear) begin
      exp_q.delete();
      m_hold = 0;
    end else if (!m_hold) begin
      if (byte_valid) begin
        m_lane[exp_q.size()] = byte_in;
        exp_q.push_back(byte_in);
        if (exp_q.size() == BB) m_hold = 1;
      end
`ifdef BUILD_BLOCK_FLUSH_PAD_EN
      if (flush && !m_hold && exp_q.size() > 0) begin
        for (int i = exp_q.size(); i < BB; i++) m_lane[i] = '0;
        m_hold = 1;
      end
`endif
    end else if (block_ready) begin
      exp_q.delete();
      m_hold = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [BLK_W-1:0] got,
                       input logic [BLK_W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [BB-1:0][BW-1:0] eb;
    check({tag, ".byte_ready"}, BLK_W'(byte_ready), BLK_W'(!m_hold));
    check({tag, ".block_valid"}, BLK_W'(block_valid), BLK_W'(m_hold));
    check({tag, ".count"}, BLK_W'(count), BLK_W'(exp_q.size()));
    if (m_hold) begin
      for (int i = 0; i < BB; i++) eb[i] = m_lane[i];
      check({tag, ".block"}, block, eb);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input string tag);
    model_update();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic send_byte(input logic [BW-1:0] b, input string tag);
    byte_in = b;
    byte_valid = 1'b1;
    tick(tag);
    byte_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #2;
    check_all("reset");
    check("reset.block", block, '0);
    @(negedge clk);
    rst = 1'b0;

    // Full block, back-to-back, no consumer.
    for (int i = 0; i < BB; i++) send_byte(BW'(i), "full");
    check("full.lane0", BLK_W'(block[0]), BLK_W'(8'h00));
    check("full.lane15", BLK_W'(block[15]), BLK_W'(8'h0F));

    // Backpressure: offered byte must be refused while held.
    byte_in = 8'hAA;
    byte_valid = 1'b1;
    for (int i = 0; i < 10; i++) tick("bp_hold");
    block_ready = 1'b1;
    tick("bp_release");
    block_ready = 1'b0;
    tick("bp_accept");
    check("bp.lane0", BLK_W'(block[0]), BLK_W'(8'hAA));
    byte_valid = 1'b0;
    block_ready = 1'b1;
    for (int i = 1; i < BB; i++) send_byte(BW'(8'hB0 + i), "bp_fill");
    tick("bp_drain");
    block_ready = 1'b0;

    // Gapped input.
    for (int i = 0; i < BB; i++) begin
      send_byte(BW'(8'h10 + i), "gap_on");
      tick("gap_off");
    end
    check("gap.lane7", BLK_W'(block[7]), BLK_W'(8'h17));
    block_ready = 1'b1;
    tick("gap_drain");
    block_ready = 1'b0;

    // Clear drops the partial block and the byte presented with it.
    for (int i = 0; i < 5; i++) send_byte(BW'(8'h50 + i), "clr_pre");
    clear = 1'b1;
    send_byte(8'h55, "clr");
    clear = 1'b0;
    for (int i = 0; i < BB; i++) send_byte(BW'(8'h20 + i), "clr_post");
    check("clr.lane0", BLK_W'(block[0]), BLK_W'(8'h20));

    // Clear together with consumer ready while held.
    clear = 1'b1;
    block_ready = 1'b1;
    tick("clr_hold");
    clear = 1'b0;
    block_ready = 1'b0;

    // Asynchronous reset in the middle of a held cycle.
    for (int i = 0; i < BB; i++) send_byte(BW'(8'h60 + i), "ar_fill");
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;

    // Flush request on a 3-byte partial block.
    send_byte(8'hA1, "fl");
    send_byte(8'hA2, "fl");
    send_byte(8'hA3, "fl");
    flush = 1'b1;
    tick("flush");
    flush = 1'b0;
`ifdef BUILD_BLOCK_FLUSH_PAD_EN
    check("flush.count", BLK_W'(count), BLK_W'(3));
    check("flush.valid", BLK_W'(block_valid), BLK_W'(1));
    block_ready = 1'b1;
    tick("flush_drain");
    block_ready = 1'b0;
`else
    check("noflush.count", BLK_W'(count), BLK_W'(3));
    check("noflush.ready", BLK_W'(byte_ready), BLK_W'(1));
    clear = 1'b1;
    tick("noflush_clr");
    clear = 1'b0;
`endif

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      byte_in     = BW'($urandom);
      byte_valid  = ($urandom_range(0, 3) != 0);
      block_ready = ($urandom_range(0, 2) == 0);
      clear       = ($urandom_range(0, 39) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      tick("rand");
    end
    byte_valid = 1'b0;
    block_ready = 1'b0;
    clear = 1'b0;
    flush = 1'b0;

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
